jtgng_romarb4: RTL and testbench
================================

// Module: jtgng_romarb4
// PURPOSE
//  Four-slot round-robin arbiter sharing the single game-side SDRAM ROM port
//  (sdram_req/sdram_ack/data_rdy/data_read) between ROM clients (main CPU,
//  sound CPU, char, obj). Sits inside the game top, between the per-client
//  ROM request logic and the frame SDRAM controller. Drives refresh_en when idle.
// PARAMETERS
//  AW   22  SDRAM word address width, per slot and on sdram_addr
//  DW   32  SDRAM read data width, per slot and on data_read
// PORTS
//  clk          in   1      system clock (48 MHz)
//  rst          in   1      synchronous reset, active high
//  loop_rst     in   1      synchronous flush: abandon the transaction, clear state
//  downloading  in   1      ROM download active: no new grants
//  slot_req     in   4      level request per slot; addr held stable until slot_ok
//  slot_addr    in   4*AW   slot i address at [i*AW +: AW]
//  slot_data    out  4*DW   slot i data at [i*DW +: DW]; held until that slot is next served
//  slot_ok      out  4      one-cycle pulse: slot data valid
//  sdram_req    out  1      request to SDRAM controller, held until sdram_ack
//  sdram_addr   out  AW     address of the granted slot, registered
//  sdram_ack    in   1      controller accepted the request
//  data_rdy     in   1      data_read valid this cycle
//  data_read    in   DW     SDRAM read data
//  refresh_en   out  1      high when the controller may refresh
// BEHAVIOUR
//  - Reset (rst or loop_rst): state IDLE; sdram_req, slot_ok, slot_data, sdram_addr = 0;
//    refresh_en = 1; rr pointer = 3, so slot 0 wins first. Both resets take effect
//    mid-transaction. A data_rdy that arrives after the flush is ignored.
//  - FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
//  - IDLE: if !downloading and any slot_req: grant the first requesting slot,
//    searching ptr+1, ptr+2 and so on modulo 4. Register g and sdram_addr. Set
//    sdram_req=1 and ptr=g. Go to REQ. sdram_req rises 1 cycle after slot_req is
//    sampled.
//  - REQ: sdram_req held, sdram_addr stable. On sdram_ack: clear sdram_req
//    (low next cycle) and go to WAIT. If data_rdy occurs in the same cycle as
//    sdram_ack, handle it as in WAIT and go straight to DONE.
//  - WAIT: on data_rdy: slot_data[g] <= data_read, slot_ok[g] <= 1, go to DONE.
//  - DONE: slot_ok pulse is visible this cycle (exactly one cycle). The cycle gives
//    the client time to drop slot_req before the next grant, so the same request is
//    never granted twice. Go to IDLE.
//  - If a slot drops slot_req after its grant, the transaction still completes and
//    slot_ok is still pulsed.
//  - downloading rising mid-transaction: the current access completes and no new
//    grants are made.
//  - refresh_en = (state==IDLE) & no grant this cycle (registered, 1-cycle lag OK).
//  - Fairness: a continuously requesting slot waits at most 3 other transactions.
//  - Minimum service time when ack and data_rdy each arrive 1 cycle after the
//    previous stage: slot_req sampled -> slot_ok = 4 cycles. Back-to-back grant
//    period = 4 cycles plus SDRAM latency.
// CONFIGURATION
//  JTGNG_ROMARB_CACHE_EN defined:
//  - Each slot keeps a last-address tag plus a valid bit. Valid is cleared by
//    rst/loop_rst and by downloading.
//  - In IDLE, the granted slot's address is checked against its tag. On a tag hit:
//    no SDRAM access, slot_ok[g] pulses the next cycle with the held slot_data, and
//    the FSM goes IDLE -> DONE -> IDLE.
//  - On a miss, the tag is updated when the data is latched.
//  Not defined: every grant goes to SDRAM; no tag registers are built.
// TESTING
//  - Reset, then slot_req=4'b0001, addr0=22'h1234. Bench acks after 2 cycles and
//    sends data_rdy=32'hCAFEBABE after 3 more -> sdram_addr=22'h1234, one slot_ok[0]
//    pulse, slot_data[0]=CAFEBABE.
//  - slot_req=4'b1111 held (each slot re-raising req after its ok) -> grant order
//    0,1,2,3,0. Exactly one slot_ok per transaction, never two in a row for the same
//    request.
//  - Ack and data_rdy in the same cycle -> FSM goes REQ->DONE, slot_ok 1 cycle
//    later, no hang.
//  - loop_rst pulsed in WAIT, then data_rdy -> no slot_ok, slot_data unchanged,
//    sdram_req=0, refresh_en=1.
//  - downloading=1 with slot_req=4'b0110 -> sdram_req stays 0, refresh_en=1. On
//    downloading=0, slot 1 is granted first.
//  - With CACHE_EN: slot 2 reads addr 22'h0040 twice -> one sdram_req. The second
//    slot_ok arrives 2 cycles after the request with the same data.

Source files
------------

// File: rtl/jtgng_romarb4.sv
// rtl/jtgng_romarb4.sv - four-slot round-robin arbiter for the shared SDRAM ROM port
// Optional feature macro: JTGNG_ROMARB_CACHE_EN (per-slot last-address tag, hits skip SDRAM)
module jtgng_romarb4 #(
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            loop_rst,
  input  logic            downloading,
  input  logic [3:0]      slot_req,
  input  logic [4*AW-1:0] slot_addr,
  output logic [4*DW-1:0] slot_data,
  output logic [3:0]      slot_ok,
  output logic            sdram_req,
  output logic [AW-1:0]   sdram_addr,
  input  logic            sdram_ack,
  input  logic            data_rdy,
  input  logic [DW-1:0]   data_read,
  output logic            refresh_en
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      g_q, g_d;
  logic            sdram_req_q, sdram_req_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [4*DW-1:0] data_q, data_d;
  logic [3:0]      ok_q, ok_d;
  logic            refresh_q, refresh_d;

  logic            flush;
  logic            gnt_vld;
  logic [1:0]      gnt_idx;
  logic [1:0]      cand;
  logic [AW-1:0]   gnt_addr;
  logic            cache_hit;
  logic            latch;

  assign flush = rst | loop_rst;

  // Round-robin search: first requesting slot after the last one granted
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    cand    = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!gnt_vld && slot_req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_addr = slot_addr[32'(gnt_idx)*AW +: AW];
  end

  // Read data is accepted in WAIT, or in REQ when it arrives together with the ack
  assign latch = data_rdy && ((state_q == S_WAIT) || (state_q == S_REQ && sdram_ack));

`ifdef JTGNG_ROMARB_CACHE_EN
  logic [AW-1:0] tag_q [4];
  logic [3:0]    tag_vld_q;

  assign cache_hit = tag_vld_q[gnt_idx] && (tag_q[gnt_idx] == gnt_addr);

  // Each slot remembers the last address fetched from SDRAM; a download invalidates all
  always_ff @(posedge clk) begin
    if (flush || downloading) begin
      tag_vld_q <= '0;
    end else if (latch) begin
      tag_vld_q[g_q] <= 1'b1;
      tag_q[g_q]     <= addr_q;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Next-state and output decode for the grant / request / wait / done sequence
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    sdram_req_d = sdram_req_q;
    addr_d      = addr_q;
    data_d      = data_q;
    ok_d        = '0;
    refresh_d   = (state_q == S_IDLE) && !(gnt_vld && !downloading);
    case (state_q)
      S_IDLE: begin
        if (!downloading && gnt_vld) begin
          g_d   = gnt_idx;
          ptr_d = gnt_idx;
          if (cache_hit) begin
            ok_d[gnt_idx] = 1'b1;
            state_d       = S_DONE;
          end else begin
            addr_d      = gnt_addr;
            sdram_req_d = 1'b1;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (sdram_ack) begin
          sdram_req_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT:  state_d = S_WAIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (latch) begin
      data_d[32'(g_q)*DW +: DW] = data_read;
      ok_d[g_q]                 = 1'b1;
      state_d                   = S_DONE;
    end
  end

  // State registers; either reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (flush) begin
      state_q     <= S_IDLE;
      ptr_q       <= 2'd3;
      g_q         <= 2'd0;
      sdram_req_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      ok_q        <= '0;
      refresh_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      sdram_req_q <= sdram_req_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ok_q        <= ok_d;
      refresh_q   <= refresh_d;
    end
  end

  assign slot_data  = data_q;
  assign slot_ok    = ok_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = addr_q;
  assign refresh_en = refresh_q;

endmodule

// File: tb/tb_jtgng_romarb4.sv
// tb/tb_jtgng_romarb4.sv - randomized self-checking bench for jtgng_romarb4
module tb_jtgng_romarb4;
  localparam int AW = 22;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst, loop_rst, downloading;
  logic [3:0]      slot_req;
  logic [4*AW-1:0] slot_addr;
  logic [4*DW-1:0] slot_data;
  logic [3:0]      slot_ok;
  logic            sdram_req;
  logic [AW-1:0]   sdram_addr;
  logic            sdram_ack, data_rdy;
  logic [DW-1:0]   data_read;
  logic            refresh_en;

  int checks   = 0;
  int failures = 0;

  // Reference model: last granted slot and the data each slot should be holding
  int            model_ptr;
  logic [DW-1:0] model_data [4];

  always #5 clk = ~clk;

  jtgng_romarb4 #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .loop_rst(loop_rst), .downloading(downloading),
    .slot_req(slot_req), .slot_addr(slot_addr), .slot_data(slot_data), .slot_ok(slot_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en)
  );

  function automatic int model_grant(input logic [3:0] m);
    for (int k = 1; k <= 4; k++)
      if (m[(model_ptr + k) % 4]) return (model_ptr + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    model_ptr = 3;
    for (int i = 0; i < 4; i++) model_data[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; loop_rst = 1'b0; downloading = 1'b0; slot_req = '0; slot_addr = '0;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // SDRAM controller stand-in; returns at the negedge where slot_ok should be visible
  task automatic serve(input int ack_dly, input int data_dly, input logic same,
                       input logic [DW-1:0] d, output logic got, output logic [AW-1:0] addr);
    int n;
    got = 1'b0; addr = '0; n = 0;
    while (!sdram_req && n < 50) begin @(negedge clk); n++; end
    if (!sdram_req) return;
    addr = sdram_addr;
    repeat (ack_dly) @(negedge clk);
    sdram_ack = 1'b1;
    if (same) begin data_rdy = 1'b1; data_read = d; end
    @(negedge clk);
    sdram_ack = 1'b0;
    if (!same) begin
      data_rdy = 1'b0;
      repeat (data_dly) @(negedge clk);
      data_rdy = 1'b1; data_read = d;
      @(negedge clk);
    end
    data_rdy = 1'b0;
    got = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL reset_sdram_req got=%b exp=0", sdram_req); end
    checks++; if (slot_ok !== 4'b0) begin failures++; $display("FAIL reset_slot_ok got=%b exp=0000", slot_ok); end
    checks++; if (slot_data !== '0) begin failures++; $display("FAIL reset_slot_data got=%h exp=0", slot_data); end
    checks++; if (sdram_addr !== '0) begin failures++; $display("FAIL reset_sdram_addr got=%h exp=0", sdram_addr); end
    checks++; if (refresh_en !== 1'b1) begin failures++; $display("FAIL reset_refresh_en got=%b exp=1", refresh_en); end
  endtask

  task automatic test_single();
    logic got; logic [AW-1:0] a;
    slot_addr[0 +: AW] = 22'h1234;
    slot_req = 4'b0001;
    serve(2, 2, 1'b0, 32'hCAFEBABE, got, a);
    checks++; if (!got) begin failures++; $display("FAIL single_timeout got=no_req exp=sdram_req"); end
    checks++; if (a !== 22'h1234) begin failures++; $display("FAIL single_addr got=%h exp=001234", a); end
    checks++; if (slot_ok !== 4'b0001) begin failures++; $display("FAIL single_ok got=%b exp=0001", slot_ok); end
    checks++; if (slot_data[0 +: DW] !== 32'hCAFEBABE) begin failures++; $display("FAIL single_data got=%h exp=cafebabe", slot_data[0 +: DW]); end
    slot_req = 4'b0000;
    @(negedge clk);
    checks++; if (slot_ok !== 4'b0) begin failures++; $display("FAIL single_ok_width got=%b exp=0000", slot_ok); end
    model_ptr = 0; model_data[0] = 32'hCAFEBABE;
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic got; logic [AW-1:0] a; logic [DW-1:0] d; int g;
    do_reset();
    for (int i = 0; i < 4; i++) slot_addr[i*AW +: AW] = AW'($urandom);
    slot_req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      g = exp_order[t];
      d = $urandom;
      serve($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, d, got, a);
      checks++; if (!got || a !== slot_addr[g*AW +: AW]) begin failures++; $display("FAIL rr_addr t=%0d got=%h exp=%h", t, a, slot_addr[g*AW +: AW]); end
      checks++; if (slot_ok !== 4'(1 << g)) begin failures++; $display("FAIL rr_ok t=%0d got=%b exp_slot=%0d", t, slot_ok, g); end
      checks++; if (slot_data[g*DW +: DW] !== d) begin failures++; $display("FAIL rr_data t=%0d got=%h exp=%h", t, slot_data[g*DW +: DW], d); end
      slot_req[g] = 1'b0;
      slot_addr[g*AW +: AW] = AW'($urandom);
      @(negedge clk);
      checks++; if (slot_ok !== 4'b0) begin failures++; $display("FAIL rr_double_ok t=%0d got=%b exp=0000", t, slot_ok); end
      slot_req[g] = 1'b1;
      model_ptr = g; model_data[g] = d;
    end
    slot_req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ack_data_same();
    logic got; logic [AW-1:0] a; logic [DW-1:0] d;
    d = $urandom;
    slot_addr[3*AW +: AW] = AW'($urandom);
    slot_req = 4'b1000;
    serve(0, 0, 1'b1, d, got, a);
    checks++; if (!got) begin failures++; $display("FAIL same_timeout got=no_req exp=sdram_req"); end
    checks++; if (slot_ok !== 4'b1000) begin failures++; $display("FAIL same_ok got=%b exp=1000", slot_ok); end
    checks++; if (slot_data[3*DW +: DW] !== d) begin failures++; $display("FAIL same_data got=%h exp=%h", slot_data[3*DW +: DW], d); end
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL same_req_low got=%b exp=0", sdram_req); end
    slot_req = 4'b0000;
    model_ptr = 3; model_data[3] = d;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loop_rst();
    int n; logic seen_ok;
    slot_addr[0 +: AW] = AW'($urandom);
    slot_req = 4'b0001;
    n = 0;
    while (!sdram_req && n < 20) begin @(negedge clk); n++; end
    checks++; if (sdram_req !== 1'b1) begin failures++; $display("FAIL loop_req_timeout got=%b exp=1", sdram_req); end
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0; slot_req = 4'b0000; loop_rst = 1'b1;
    @(negedge clk);
    loop_rst = 1'b0; data_rdy = 1'b1; data_read = $urandom;
    @(negedge clk);
    data_rdy = 1'b0;
    model_reset();
    seen_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (slot_ok !== 4'b0) seen_ok = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen_ok !== 1'b0) begin failures++; $display("FAIL loop_ok got=pulse exp=none"); end
    checks++; if (slot_data[0 +: DW] !== model_data[0]) begin failures++; $display("FAIL loop_data got=%h exp=%h", slot_data[0 +: DW], model_data[0]); end
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL loop_sdram_req got=%b exp=0", sdram_req); end
    checks++; if (refresh_en !== 1'b1) begin failures++; $display("FAIL loop_refresh got=%b exp=1", refresh_en); end
  endtask

  task automatic test_download();
    logic got; logic [AW-1:0] a; logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < 4; i++) slot_addr[i*AW +: AW] = AW'($urandom);
    downloading = 1'b1;
    slot_req = 4'b0110;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (sdram_req !== 1'b0 || refresh_en !== 1'b1) begin failures++; $display("FAIL dl_hold cyc=%0d got_req=%b got_refresh=%b exp=0/1", i, sdram_req, refresh_en); end
    end
    downloading = 1'b0;
    d = $urandom;
    serve(1, 1, 1'b0, d, got, a);
    checks++; if (!got || a !== slot_addr[1*AW +: AW]) begin failures++; $display("FAIL dl_first_addr got=%h exp=%h", a, slot_addr[1*AW +: AW]); end
    checks++; if (slot_ok !== 4'b0010) begin failures++; $display("FAIL dl_first_ok got=%b exp=0010", slot_ok); end
    slot_req = 4'b0000;
    model_ptr = 1; model_data[1] = d;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic got; logic [AW-1:0] a; logic [DW-1:0] d; logic [3:0] m; int g;
    for (int t = 0; t < 30; t++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) slot_addr[i*AW +: AW] = AW'($urandom);
      slot_req = m;
      g = model_grant(m);
      d = $urandom;
      serve($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), d, got, a);
      model_data[g] = d;
      model_ptr = g;
      checks++; if (!got || a !== slot_addr[g*AW +: AW]) begin failures++; $display("FAIL rand_addr t=%0d mask=%b got=%h exp=%h", t, m, a, slot_addr[g*AW +: AW]); end
      checks++; if (slot_ok !== 4'(1 << g)) begin failures++; $display("FAIL rand_ok t=%0d mask=%b got=%b exp_slot=%0d", t, m, slot_ok, g); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (slot_data[i*DW +: DW] !== model_data[i]) begin failures++; $display("FAIL rand_data t=%0d slot=%0d got=%h exp=%h", t, i, slot_data[i*DW +: DW], model_data[i]); end
      end
      slot_req = 4'b0000;
      repeat (2) @(negedge clk);
      checks++; if (slot_ok !== 4'b0 || refresh_en !== 1'b1) begin failures++; $display("FAIL rand_idle t=%0d got_ok=%b got_refresh=%b exp=0000/1", t, slot_ok, refresh_en); end
    end
  endtask

`ifdef JTGNG_ROMARB_CACHE_EN
  task automatic test_cache();
    logic got; logic [AW-1:0] a; logic [DW-1:0] d; int n, reqs; logic ok_seen;
    do_reset();
    d = $urandom;
    slot_addr[2*AW +: AW] = 22'h0040;
    slot_req = 4'b0100;
    serve(1, 1, 1'b0, d, got, a);
    checks++; if (!got || slot_ok !== 4'b0100) begin failures++; $display("FAIL cache_first got=%b exp=0100", slot_ok); end
    slot_req = 4'b0000;
    repeat (2) @(negedge clk);
    slot_req = 4'b0100;
    n = 0; reqs = 0; ok_seen = 1'b0;
    while (n < 8 && !ok_seen) begin
      @(negedge clk); n++;
      if (sdram_req) reqs++;
      if (slot_ok[2]) ok_seen = 1'b1;
    end
    checks++; if (!ok_seen) begin failures++; $display("FAIL cache_hit_ok got=none exp=pulse"); end
    checks++; if (reqs != 0) begin failures++; $display("FAIL cache_hit_req got=%0d exp=0", reqs); end
    checks++; if (slot_data[2*DW +: DW] !== d) begin failures++; $display("FAIL cache_hit_data got=%h exp=%h", slot_data[2*DW +: DW], d); end
    slot_req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ack_data_same();
    test_loop_rst();
    test_download();
    test_random();
`ifdef JTGNG_ROMARB_CACHE_EN
    test_cache();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
